posit_encode: RTL
=================

// Module: posit_encode
// PURPOSE
//  Multi-cycle posit packer: takes an unpacked value (sign, signed scale, fraction, sticky) and
//  builds the N-bit posit with round-to-nearest-even and saturation. This is the encode end of
//  the posit datapath; the multiplier's decode/normalise output feeds it. Uses the same
//  start/done handshake and NAR/ZERO flags as posit_mul.
// PARAMETERS
//  N       32  posit width
//  ES      3   exponent field width; useed = 2^(2^ES)
//  FRAC_W  32  input fraction width; hidden 1 excluded, MSB-aligned (weight 2^-1)
//  SCALE_W 10  signed scale width; scale = k*2^ES + e
// PORTS
//  clk           in   1        clock, rising edge
//  rst_n         in   1        asynchronous active-low reset
//  start         in   1        1-cycle request; sampled only in IDLE
//  sign_in       in   1        result sign
//  scale_in      in   SCALE_W  signed two's-complement scale (power of two)
//  frac_in       in   FRAC_W   fraction bits below the hidden 1
//  sticky_in     in   1        OR of discarded bits below frac_in LSB
//  nar_in        in   1        force NaR; priority over zero_in
//  zero_in       in   1        force zero
//  busy          out  1        high from accepted start until done
//  done          out  1        1-cycle pulse; posit_result valid from this cycle
//  posit_result  out  N        encoded posit; held until next accepted start
//  NAR           out  1        result is NaR (0x80000000); held with result
//  ZERO          out  1        result is zero; held with result
// BEHAVIOUR
//  Reset: state IDLE; busy, done, NAR, ZERO = 0; posit_result = 0. Reset mid-operation aborts
//   with no done pulse.
//  Inputs are captured on the edge that accepts start; later input changes have no effect.
//   start while busy is ignored.
//  FSM: IDLE -(start)-> LOAD -> SHIFT (L cycles) -> ROUND -> DONE -> IDLE.
//   Special/saturated cases go LOAD -> DONE.
//  LOAD: k = scale_in >>> ES, e = scale_in[ES-1:0].
//   nar_in -> result 0x80000000, NAR=1.
//   else zero_in -> 0, ZERO=1.
//   else k >= N-2 -> maxpos 0x7FFFFFFF.
//   else k <= -(N-1) -> minpos 0x00000001. Sign applied after this.
//   Otherwise load the shift register {e, frac_in}, with sticky_in as the sticky accumulator.
//  Regime length L = k+2 for k >= 0 (k+1 ones, then a 0); L = -k+1 for k < 0 (-k zeros, then a 1).
//   Valid range 2..N-1.
//  SHIFT: one regime bit per cycle enters at the MSB of a (2N)-bit register. Bits shifted out the
//   bottom OR into sticky.
//  ROUND: magnitude m = top N-1 bits after the sign position; guard = next bit; sticky = OR of
//   the rest. Increment when guard & (sticky | m[0]) (RNE); carries ripple naturally into
//   exp/regime. Clamp m = 0 to 1 (never round to zero). Clamp overflow to 0x7FFFFFFF
//   (never round to NaR).
//  Sign: if sign_in and not NAR/ZERO, posit_result = two's complement of {0, m}.
//  Latency, start-sampling edge to done: L+3 cycles (normal); 2 cycles (special/saturated).
//   busy falls in the same cycle done rises. A start is accepted on the cycle after done.
// TESTING
//  scale 0, frac 0 -> 0x40000000, 5 cycles; scale 0, frac 0x80000000 -> 0x42000000 (1.5).
//  scale -1, frac 0x80000000 -> 0x3E000000 (0.75); sign=1, scale 0, frac 0 -> 0xC0000000.
//  scale 0, frac 0xFFFFFFFF -> RNE carry into exponent -> 0x44000000 (2.0).
//  scale 300 -> 0x7FFFFFFF; sign=1 -> 0x80000001; scale -300 -> 0x00000001; latency 2.
//  nar_in=1 & zero_in=1 -> 0x80000000, NAR=1, ZERO=0; zero_in only -> 0, ZERO=1.
//  start during busy ignored; rst_n low mid-SHIFT -> no done, outputs 0; next request correct.

Source files
------------

// File: rtl/posit_encode.sv
// posit_encode: multi-cycle posit packer.
//
// Turns an unpacked value (sign, signed power-of-two scale, fraction below the
// hidden 1, sticky) into an N-bit posit. The regime is built serially, one bit
// per cycle, by shifting into the top of a 2N-bit register. The register is
// preloaded with {exponent, fraction}. Rounding is round-to-nearest-even. The
// result never rounds to zero and never rounds to NaR. Scales outside the
// regime range saturate to maxpos or minpos. Start/done handshake and the
// NAR/ZERO flags match posit_mul.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             1-cycle request, sampled only when idle
//   sign_in           result sign
//   scale_in          signed scale = k*2^ES + e
//   frac_in           fraction bits below the hidden 1, MSB weight 2^-1
//   sticky_in         OR of discarded bits below frac_in
//   nar_in, zero_in   force NaR / zero (NaR wins)
//   busy              high from accepted start until done
//   done              1-cycle pulse, result valid from this cycle
//   posit_result      encoded posit, held until the next result
//   NAR, ZERO         result flags, held with posit_result
module posit_encode #(
  parameter int N       = 32,
  parameter int ES      = 3,
  parameter int FRAC_W  = 32,
  parameter int SCALE_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sign_in,
  input  logic [SCALE_W-1:0] scale_in,
  input  logic [FRAC_W-1:0]  frac_in,
  input  logic               sticky_in,
  input  logic               nar_in,
  input  logic               zero_in,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       posit_result,
  output logic               NAR,
  output logic               ZERO
);

  localparam int W  = 2*N;
  localparam int CW = $clog2(N+1);

  // Regime run length k outside [-(N-2), N-3] cannot fit; saturate.
  localparam logic signed [SCALE_W-1:0] K_HI = SCALE_W'(N-2);
  localparam logic signed [SCALE_W-1:0] K_LO = SCALE_W'(-(N-1));
  localparam logic [N-1:0]              NAR_PAT = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_ROUND, S_DONE} state_e;

  typedef struct packed {
    logic               sign;
    logic [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]  frac;
    logic               sticky;
    logic               nar;
    logic               zero;
  } req_t;

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [W-1:0]     sh_q, sh_d;
  logic             sticky_q, sticky_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    len_q, len_d;
  logic             run_q, run_d;      // value of the regime run bits
  logic [N-2:0]     mag_q, mag_d;      // magnitude below the sign bit
  logic             nar_q, nar_d;
  logic             zero_q, zero_d;
  logic [N-1:0]     res_q, res_d;
  logic             nar_out_q, nar_out_d;
  logic             zero_out_q, zero_out_d;
  logic             done_q, done_d;

  // ---------------- LOAD decode ----------------
  logic signed [SCALE_W-1:0] k_s;
  logic                      k_neg;
  logic [CW-1:0]             k_lo;
  logic [CW-1:0]             len_w;
  logic [ES-1:0]             e_w;

  assign k_s   = $signed(req_q.scale) >>> ES;
  assign k_neg = k_s[SCALE_W-1];
  assign k_lo  = k_s[CW-1:0];
  // L = k+2 for k >= 0, -k+1 for k < 0; only used inside the legal range,
  // so modulo-2^CW arithmetic is exact.
  assign len_w = k_neg ? (CW'(1) - k_lo) : (k_lo + CW'(2));
  assign e_w   = req_q.scale[ES-1:0];

  // ---------------- SHIFT ----------------
  // The regime is shifted in last-bit-first: the terminating bit goes in
  // first, then the run, so the first regime bit ends up at the MSB.
  logic reg_bit;
  assign reg_bit = (cnt_q == '0) ? ~run_q : run_q;

  // ---------------- ROUND ----------------
  logic [N-2:0] m_w;
  logic         guard_w;
  logic         rest_w;
  logic         inc_w;
  logic [N-1:0] m_sum;
  logic [N-2:0] m_sat;
  logic [N-2:0] m_rnd;

  assign m_w     = sh_q[W-1 -: N-1];
  assign guard_w = sh_q[W-N];
  assign rest_w  = (|sh_q[W-N-1:0]) | sticky_q;
  assign inc_w   = guard_w & (rest_w | m_w[0]);
  assign m_sum   = {1'b0, m_w} + {{(N-1){1'b0}}, inc_w};
  // A carry out of the magnitude would land on NaR: hold at maxpos instead.
  assign m_sat   = m_sum[N-1] ? {(N-1){1'b1}} : m_sum[N-2:0];
  assign m_rnd   = (m_sat == '0) ? {{(N-2){1'b0}}, 1'b1} : m_sat;

  // ---------------- final pack ----------------
  logic [N-1:0] signed_res;
  assign signed_res = req_q.sign ? (~{1'b0, mag_q} + N'(1)) : {1'b0, mag_q};

  // A start that lands on the done cycle is not taken; the earliest accepted
  // start is the cycle after done.
  logic accept;
  assign accept = start & (state_q == S_IDLE) & ~done_q;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    sh_d       = sh_q;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    run_d      = run_q;
    mag_d      = mag_q;
    nar_d      = nar_q;
    zero_d     = zero_q;
    res_d      = res_q;
    nar_out_d  = nar_out_q;
    zero_out_d = zero_out_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_d   = '{sign:   sign_in,   scale: scale_in, frac: frac_in,
                      sticky: sticky_in, nar:   nar_in,   zero: zero_in};
          nar_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        state_d = S_DONE;
        if (req_q.nar) begin
          nar_d = 1'b1;
        end else if (req_q.zero) begin
          zero_d = 1'b1;
        end else if (k_s >= K_HI) begin
          mag_d = {(N-1){1'b1}};
        end else if (k_s <= K_LO) begin
          mag_d = {{(N-2){1'b0}}, 1'b1};
        end else begin
          sh_d     = {e_w, req_q.frac, {(W-ES-FRAC_W){1'b0}}};
          sticky_d = req_q.sticky;
          cnt_d    = '0;
          len_d    = len_w;
          run_d    = ~k_neg;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sh_d     = {reg_bit, sh_q[W-1:1]};
        sticky_d = sticky_q | sh_q[0];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == len_q - CW'(1)) state_d = S_ROUND;
      end

      S_ROUND: begin
        mag_d   = m_rnd;
        state_d = S_DONE;
      end

      S_DONE: begin
        res_d      = nar_q ? NAR_PAT : (zero_q ? '0 : signed_res);
        nar_out_d  = nar_q;
        zero_out_d = zero_q;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      sh_q       <= '0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
      run_q      <= 1'b0;
      mag_q      <= '0;
      nar_q      <= 1'b0;
      zero_q     <= 1'b0;
      res_q      <= '0;
      nar_out_q  <= 1'b0;
      zero_out_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      sh_q       <= sh_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      run_q      <= run_d;
      mag_q      <= mag_d;
      nar_q      <= nar_d;
      zero_q     <= zero_d;
      res_q      <= res_d;
      nar_out_q  <= nar_out_d;
      zero_out_q <= zero_out_d;
      done_q     <= done_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign posit_result = res_q;
  assign NAR          = nar_out_q;
  assign ZERO         = zero_out_q;

endmodule
